inj_patgen_multi: RTL
=====================

Name: inj_patgen_multi

Overview:
- Multi-channel injection pulse generator; parametrised successor of the single-output injection pattern generator.
- Drives NCH independent injection chopper lines, e.g. GECCO injection, chip injection and extra test injection points.
- Each channel has its own period, high time, pulse count and initial delay. Registers are programmed through the FTDI order-sorter byte-write interface.
- Sits between the FTDI register block and the output buffers (OBUFDS / plain outputs).

Parameters:
- NCH, 4, number of channels (1..16).
- CNT_W, 16, width of period/high/delay/pulse counters (8..16); register bytes above CNT_W are ignored.
- SYNC_STAGES, 2, synchroniser depth for sync_in.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- res_n  in  1  asynchronous active-low reset.
- wr_strobe  in  1  one-cycle byte write strobe.
- wr_addr  in  8  register address.
- wr_data  in  8  register data.
- start  in  1  one-cycle pulse: launch all enabled channels.
- stop  in  1  one-cycle pulse: abort all channels to IDLE.
- suspend  in  1  level: freeze all counters, force outputs low.
- sync_in  in  1  asynchronous external sync/trigger.
- inj_out  out  NCH  registered injection outputs.
- running  out  NCH  channel in DELAY/HIGH/LOW.
- done  out  NCH  sticky, set when pulse count is reached; cleared by start/stop.

Behaviour:
- Reset: all registers 0, all channels IDLE; inj_out, running and done all 0.
- Channel register map, ch = wr_addr[6:3] (wr_addr[7]=0), sub-address = wr_addr[2:0]:
  - 0/1: period lo/hi
  - 2/3: high lo/hi
  - 4/5: npulses lo/hi
  - 6/7: initdelay lo/hi
- Global registers:
  - 0x80: enable mask [7:0].
  - 0x81: enable mask [15:8].
  - 0x82: bit0 synced_mode, bit1 restart_on_done.
- Writes to channel index ≥ NCH and to unmapped addresses are ignored. Writes take effect on the next clk.
- Shadowing: on launch, each enabled channel copies its registers into working copies. Writes during a run do not affect it until the next launch.
- Launch:
  - synced_mode=0: start itself is the launch.
  - synced_mode=1: start arms the block; the launch is the first rising edge of sync_in after synchronisation (latency SYNC_STAGES+1 cycles). A second start while armed is ignored.
- Per-channel FSM: IDLE -> DELAY -> ACTIVE -> DONE.
  - At launch: initdelay=0 goes straight to ACTIVE; otherwise DELAY for initdelay cycles.
  - Timing: a launch at edge k gives first inj_out high at edge k+1+initdelay.
  - ACTIVE: phase counter runs 0..period-1 and wraps; period=0 is treated as 1. inj_out = (phase < high), registered; high=0 keeps output low, high ≥ period keeps it constant high.
  - Pulse counting: the pulse counter increments on each phase wrap. When it equals npulses (npulses ≠ 0), go to DONE: inj_out=0, running=0, done=1. npulses=0 means run forever.
  - restart_on_done=1: DONE re-launches the channel on the next cycle with its shadow values.
- suspend=1: counters, FSM state and arm flag hold; inj_out forced 0. Resuming continues exactly where it stopped.
- stop: all channels go to IDLE on the next edge, the arm flag clears, done clears. stop and start in the same cycle: stop wins. start during a run re-launches all enabled channels from scratch. suspend has no effect on stop.
- Disabled channels stay IDLE and output 0. Clearing a channel's enable bit mid-run does not stop that channel; stop does.

Decomposition:
- Package inj_patgen_pkg:
  - Register address constants (CH_STRIDE=8, SUB_PERIOD..SUB_DELAY, ADDR_EN_LO=0x80, ADDR_EN_HI=0x81, ADDR_MODE=0x82).
  - Channel state enum {IDLE, DELAY, ACTIVE, DONE}.
- Sub-module inj_channel, instantiated NCH times with a generate loop:
  - Holds the shadow registers, counters and FSM for one channel.
  - The top holds the register file, enable/mode registers, sync_in synchroniser/edge detect and launch/arm logic.

Test Plan:
- Ch0 period=10, high=3, npulses=4, delay=0, en=0x01; start at edge k -> inj_out[0] high on edges k+1..k+3, low k+4..k+10, 4 pulses total, done[0]=1 from k+41, running[0]=0.
- Ch1 delay=5, period=4, high=2, npulses=0; ch2 high=0 -> ch1 first high at k+6 and runs indefinitely; ch2 never high; stop -> all outputs 0 next cycle, done cleared.
- synced_mode=1, start, then sync_in rises 20 cycles later -> first high exactly SYNC_STAGES+1+1 cycles after the sync_in edge; a second sync_in edge causes no re-launch.
- suspend held 7 cycles mid-high-phase -> output 0 during suspend, then resumes with the remaining high count; total period stretched by exactly 7.
- Rewrite ch0 period during a run -> current run unchanged; next start uses the new value. Write to ch index 9 with NCH=4 -> no register changes.
- res_n asserted mid-run (asynchronous, between edges) -> outputs 0 immediately; after release, registers read back 0 and start produces no output.

Source files
------------

// File: rtl/inj_patgen_pkg.sv
// Shared definitions for the multi-channel injection pulse generator:
// register map constants, per-channel state encoding and a byte-merge helper
// used by the register file.
package inj_patgen_pkg;

    // Each channel owns eight consecutive byte addresses.
    localparam int CH_STRIDE = 8;

    // Sub-addresses inside a channel block. Bit 0 selects the low or high byte.
    localparam logic [2:0] SUB_PERIOD  = 3'd0;
    localparam logic [2:0] SUB_HIGH    = 3'd2;
    localparam logic [2:0] SUB_NPULSES = 3'd4;
    localparam logic [2:0] SUB_DELAY   = 3'd6;

    // Global registers (wr_addr[7] = 1).
    localparam logic [7:0] ADDR_EN_LO = 8'h80;
    localparam logic [7:0] ADDR_EN_HI = 8'h81;
    localparam logic [7:0] ADDR_MODE  = 8'h82;

    localparam int MODE_SYNCED_BIT  = 0;
    localparam int MODE_RESTART_BIT = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        ACTIVE = 2'd2,
        DONE   = 2'd3
    } ch_state_e;

    // Replace one byte of a 16-bit register image.
    function automatic logic [15:0] merge_byte(input logic [15:0] old,
                                               input logic [7:0]  data,
                                               input logic        hi);
        logic [15:0] r;
        r = old;
        if (hi) r[15:8] = data;
        else    r[7:0]  = data;
        return r;
    endfunction

endpackage

// File: rtl/inj_patgen_multi_if.sv
// Byte-write register bus from the FTDI order sorter.
// wr_strobe qualifies wr_addr/wr_data for exactly one clk cycle; there is no
// backpressure, every strobed byte is accepted on the edge it is sampled.
// Signals: wr_strobe (1), wr_addr (8), wr_data (8).
interface inj_patgen_multi_if;
    logic       wr_strobe;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;

    modport master (output wr_strobe, wr_addr, wr_data);
    modport slave  (input  wr_strobe, wr_addr, wr_data);
endinterface

// File: rtl/inj_channel.sv
// One injection channel: shadow copies of the channel registers, delay/phase/
// pulse counters and the IDLE -> DELAY -> ACTIVE -> DONE state machine.
// Ports:
//   clk, res_n          clock, asynchronous active-low reset
//   launch              load shadows from cfg_* and start from scratch
//   abort               return to IDLE, clear outputs (wins over launch)
//   suspend             freeze everything, force inj_out low
//   restart_on_done     relaunch from shadows the cycle after DONE
//   cfg_*               live register values, sampled only at launch
//   inj_out/running/done registered channel outputs
//   state_dbg           current FSM state
module inj_channel
    import inj_patgen_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic             launch,
    input  logic             abort,
    input  logic             suspend,
    input  logic             restart_on_done,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_high,
    input  logic [CNT_W-1:0] cfg_npulses,
    input  logic [CNT_W-1:0] cfg_delay,
    output logic             inj_out,
    output logic             running,
    output logic             done,
    output ch_state_e        state_dbg
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] per_q, per_d, hi_q, hi_d, np_q, np_d, dly_q, dly_d;
    logic [CNT_W-1:0] phase_q, phase_d, pcnt_q, pcnt_d, dcnt_q, dcnt_d;
    logic             inj_q, inj_d, run_q, run_d, done_q, done_d;
    logic [CNT_W-1:0] per_last;

    // Last phase index of a period; a period of 0 behaves like 1.
    assign per_last = (per_q == '0) ? '0 : per_q - ONE;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q <= IDLE;
            per_q   <= '0;
            hi_q    <= '0;
            np_q    <= '0;
            dly_q   <= '0;
            phase_q <= '0;
            pcnt_q  <= '0;
            dcnt_q  <= '0;
            inj_q   <= 1'b0;
            run_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            per_q   <= per_d;
            hi_q    <= hi_d;
            np_q    <= np_d;
            dly_q   <= dly_d;
            phase_q <= phase_d;
            pcnt_q  <= pcnt_d;
            dcnt_q  <= dcnt_d;
            inj_q   <= inj_d;
            run_q   <= run_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        per_d   = per_q;
        hi_d    = hi_q;
        np_d    = np_q;
        dly_d   = dly_q;
        phase_d = phase_q;
        pcnt_d  = pcnt_q;
        dcnt_d  = dcnt_q;
        inj_d   = inj_q;
        run_d   = run_q;
        done_d  = done_q;

        if (abort) begin
            state_d = IDLE;
            phase_d = '0;
            pcnt_d  = '0;
            dcnt_d  = '0;
            inj_d   = 1'b0;
            run_d   = 1'b0;
            done_d  = 1'b0;
        end else if (suspend) begin
            // Everything holds; only the line is forced low.
            inj_d = 1'b0;
        end else begin
            // Outputs lag the state by one edge, so a launch at edge k shows
            // its first high phase at edge k+1.
            inj_d  = (state_q == ACTIVE) && (phase_q < hi_q);
            run_d  = (state_q == DELAY) || (state_q == ACTIVE);
            done_d = done_q || (state_q == DONE);

            if (launch) begin
                per_d   = cfg_period;
                hi_d    = cfg_high;
                np_d    = cfg_npulses;
                dly_d   = cfg_delay;
                phase_d = '0;
                pcnt_d  = '0;
                dcnt_d  = cfg_delay;
                state_d = (cfg_delay == '0) ? ACTIVE : DELAY;
                done_d  = 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: ;
                    DELAY: begin
                        if (dcnt_q <= ONE) state_d = ACTIVE;
                        else               dcnt_d  = dcnt_q - ONE;
                    end
                    ACTIVE: begin
                        if (phase_q >= per_last) begin
                            phase_d = '0;
                            pcnt_d  = pcnt_q + ONE;
                            if ((np_q != '0) && (pcnt_q + ONE == np_q))
                                state_d = DONE;
                        end else begin
                            phase_d = phase_q + ONE;
                        end
                    end
                    DONE: begin
                        if (restart_on_done) begin
                            phase_d = '0;
                            pcnt_d  = '0;
                            dcnt_d  = dly_q;
                            state_d = (dly_q == '0) ? ACTIVE : DELAY;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign inj_out   = inj_q;
    assign running   = run_q;
    assign done      = done_q;
    assign state_dbg = state_q;

endmodule

// File: rtl/inj_patgen_multi.sv
// Multi-channel injection pulse generator. Holds the register file, enable
// and mode registers, the sync_in synchroniser/edge detector and the
// launch/arm logic, and instantiates one inj_channel per output line.
// Ports:
//   clk, res_n        clock, asynchronous active-low reset
//   wr_bus            byte-write register bus (slave side)
//   start, stop       one-cycle launch / abort pulses (stop wins)
//   suspend           level: freeze all channels, outputs low
//   sync_in           asynchronous external trigger (synced mode)
//   inj_out           registered injection outputs
//   running, done     per-channel status
//   dbg_state         per-channel FSM state, 2 bits per channel
module inj_patgen_multi
    import inj_patgen_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 res_n,
    inj_patgen_multi_if.slave    wr_bus,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 suspend,
    input  logic                 sync_in,
    output logic [NCH-1:0]       inj_out,
    output logic [NCH-1:0]       running,
    output logic [NCH-1:0]       done,
    output logic [2*NCH-1:0]     dbg_state
);

    localparam int CH_LSB = $clog2(CH_STRIDE);

    logic                   synced_mode, restart_on_done;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_last_q, sync_rise_q;
    logic                   armed_q;
    logic                   launch;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            synced_mode     <= 1'b0;
            restart_on_done <= 1'b0;
        end else if (wr_bus.wr_strobe && (wr_bus.wr_addr == ADDR_MODE)) begin
            synced_mode     <= wr_bus.wr_data[MODE_SYNCED_BIT];
            restart_on_done <= wr_bus.wr_data[MODE_RESTART_BIT];
        end
    end

    // The rise is registered once more after edge detection so a launch lands
    // SYNC_STAGES+1 edges after sync_in is first sampled high.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            sync_q      <= '0;
            sync_last_q <= 1'b0;
            sync_rise_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], sync_in};
            sync_last_q <= sync_q[SYNC_STAGES-1];
            sync_rise_q <= sync_q[SYNC_STAGES-1] & ~sync_last_q;
        end
    end

    always_comb begin
        launch = 1'b0;
        if (!stop && !suspend)
            launch = synced_mode ? (armed_q && sync_rise_q) : start;
    end

    // Arm flag: set by start in synced mode, consumed by the first sync rise.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n)                         armed_q <= 1'b0;
        else if (stop)                      armed_q <= 1'b0;
        else if (suspend)                   armed_q <= armed_q;
        else if (!synced_mode)              armed_q <= 1'b0;
        else if (armed_q && sync_rise_q)    armed_q <= 1'b0;
        else if (start)                     armed_q <= 1'b1;
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic [CNT_W-1:0] period_r, high_r, npulses_r, delay_r;
        logic             en_r;
        logic             ch_sel;
        ch_state_e        ch_state;

        // Channel indices >= NCH never match, so those writes fall through.
        assign ch_sel = wr_bus.wr_strobe && !wr_bus.wr_addr[7] &&
                        (wr_bus.wr_addr[CH_LSB +: 4] == 4'(g));

        always_ff @(posedge clk or negedge res_n) begin
            if (!res_n) begin
                period_r  <= '0;
                high_r    <= '0;
                npulses_r <= '0;
                delay_r   <= '0;
                en_r      <= 1'b0;
            end else begin
                if (ch_sel) begin
                    case (wr_bus.wr_addr[2:0] & 3'b110)
                        SUB_PERIOD:  period_r  <= CNT_W'(merge_byte(16'(period_r),
                                         wr_bus.wr_data, wr_bus.wr_addr[0]));
                        SUB_HIGH:    high_r    <= CNT_W'(merge_byte(16'(high_r),
                                         wr_bus.wr_data, wr_bus.wr_addr[0]));
                        SUB_NPULSES: npulses_r <= CNT_W'(merge_byte(16'(npulses_r),
                                         wr_bus.wr_data, wr_bus.wr_addr[0]));
                        SUB_DELAY:   delay_r   <= CNT_W'(merge_byte(16'(delay_r),
                                         wr_bus.wr_data, wr_bus.wr_addr[0]));
                        default: ;
                    endcase
                end
                if (wr_bus.wr_strobe &&
                    (wr_bus.wr_addr == ((g < 8) ? ADDR_EN_LO : ADDR_EN_HI)))
                    en_r <= wr_bus.wr_data[g % 8];
            end
        end

        inj_channel #(.CNT_W(CNT_W)) u_ch (
            .clk             (clk),
            .res_n           (res_n),
            .launch          (launch && en_r),
            .abort           (stop),
            .suspend         (suspend),
            .restart_on_done (restart_on_done),
            .cfg_period      (period_r),
            .cfg_high        (high_r),
            .cfg_npulses     (npulses_r),
            .cfg_delay       (delay_r),
            .inj_out         (inj_out[g]),
            .running         (running[g]),
            .done            (done[g]),
            .state_dbg       (ch_state)
        );

        assign dbg_state[2*g +: 2] = ch_state;
    end

endmodule
